// File: rtl/cve2_register_file_mp.sv
// Flip-flop register file: N combinational read ports, one staged write
// port with read forwarding, and a post-reset zero-fill sweep.
module cve2_register_file_mp #(
    parameter bit                    RV32E             = 1'b0,
    parameter int unsigned           DataWidth         = 32,
    parameter int unsigned           NumReadPorts      = 2,
    parameter bit                    DummyInstructions = 1'b0,
    parameter logic [DataWidth-1:0]  WordZeroVal       = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              dummy_instr_id_i,
    input  logic [NumReadPorts*5-1:0]         raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    input  logic [4:0]                        waddr_a_i,
    input  logic [DataWidth-1:0]              wdata_a_i,
    input  logic                              we_a_i,
    output logic                              init_done_o,
    output logic                              err_o
);

    localparam int unsigned NumWords  = RV32E ? 16 : 32;
    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam logic [AddrWidth-1:0] LastPtr = AddrWidth'(NumWords - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e                 r_state;
    logic [AddrWidth-1:0]   r_ptr;
    logic                   r_init_done;
    logic                   r_err;
    logic                   r_we_q;
    logic [AddrWidth-1:0]   r_waddr_q;
    logic [DataWidth-1:0]   r_wdata_q;
    logic                   r_wdummy_q;
    logic [DataWidth-1:0]   r_mem [NumWords];
    logic [AddrWidth-1:0]   w_waddr;
    logic [DataWidth-1:0]   w_mem_r0;
    logic                   w_unused;

    assign w_waddr     = waddr_a_i[AddrWidth-1:0];
    assign init_done_o = r_init_done;
    assign err_o       = r_err;
    assign w_unused    = ^{raddr_i, waddr_a_i, r_wdummy_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_INIT;
            r_ptr       <= AddrWidth'(1);
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
            r_we_q      <= 1'b0;
            r_waddr_q   <= '0;
            r_wdata_q   <= WordZeroVal;
            r_wdummy_q  <= 1'b0;
        end else begin
            unique case (r_state)
                S_INIT: begin
                    r_we_q <= 1'b0;
                    if (we_a_i) r_err <= 1'b1;
                    if (r_ptr == LastPtr) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + AddrWidth'(1);
                    end
                end
                S_RUN: begin
                    r_we_q <= we_a_i;
                    if (we_a_i) begin
                        r_waddr_q  <= w_waddr;
                        r_wdata_q  <= wdata_a_i;
                        r_wdummy_q <= dummy_instr_id_i;
                    end
                end
            endcase
        end
    end

    // Storage is never reset; the INIT sweep is what clears it.
    always_ff @(posedge clk_i) begin
        if (r_state == S_INIT) begin
            r_mem[r_ptr] <= WordZeroVal;
        end else if (r_we_q && (r_waddr_q != '0)) begin
            r_mem[r_waddr_q] <= r_wdata_q;
        end
    end

    if (DummyInstructions) begin : g_r0
        logic [DataWidth-1:0] r_mem_r0;
        logic                 w_commit_r0;

        assign w_commit_r0 = r_we_q && (r_waddr_q == '0) && r_wdummy_q;

        always_ff @(posedge clk_i) begin
            if (r_state == S_INIT) begin
                if (r_ptr == AddrWidth'(1)) r_mem_r0 <= WordZeroVal;
            end else if (w_commit_r0) begin
                r_mem_r0 <= r_wdata_q;
            end
        end

        assign w_mem_r0 = r_mem_r0;
    end else begin : g_no_r0
        assign w_mem_r0 = WordZeroVal;
    end

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
        logic [AddrWidth-1:0] w_ra;
        logic [DataWidth-1:0] w_rd;

        assign w_ra = raddr_i[5*p +: AddrWidth];

        always_comb begin
            w_rd = r_mem[w_ra];
            if (!r_init_done) begin
                w_rd = WordZeroVal;
            end else if (w_ra == '0) begin
                w_rd = (DummyInstructions && dummy_instr_id_i) ? w_mem_r0 : WordZeroVal;
            end else if (r_we_q && (r_waddr_q == w_ra)) begin
                w_rd = r_wdata_q;
            end
        end

        assign rdata_o[DataWidth*p +: DataWidth] = w_rd;
    end

endmodule

// File: tb/tb_cve2_register_file_mp.sv
// Bench for cve2_register_file_mp: vector table, random traffic against an
// architectural model, init timing, x0/dummy and mid-write reset cases.
module tb_cve2_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        dummy, we;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        init_done, err;

    logic        e_dummy, e_we;
    logic [9:0]  e_raddr;
    logic [63:0] e_rdata;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_init_done, e_err;

    cve2_register_file_mp dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .dummy_instr_id_i(dummy),
        .raddr_i         (raddr),
        .rdata_o         (rdata),
        .waddr_a_i       (waddr),
        .wdata_a_i       (wdata),
        .we_a_i          (we),
        .init_done_o     (init_done),
        .err_o           (err)
    );

    cve2_register_file_mp #(
        .RV32E            (1'b1),
        .DummyInstructions(1'b1)
    ) dut_e (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .dummy_instr_id_i(e_dummy),
        .raddr_i         (e_raddr),
        .rdata_o         (e_rdata),
        .waddr_a_i       (e_waddr),
        .wdata_a_i       (e_wdata),
        .we_a_i          (e_we),
        .init_done_o     (e_init_done),
        .err_o           (e_err)
    );

    int checks = 0;
    int failures = 0;

    // Architectural view: a write sampled at an edge is visible from the next cycle.
    logic [31:0] arch [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : arch[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    endtask

    task automatic run_cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                             input logic [4:0] r0, input logic [4:0] r1);
        we    = w;
        waddr = wa;
        wdata = wd;
        raddr = {r1, r0};
        #2;
        chk("rd_p0", rdata[31:0], model_rd(r0));
        chk("rd_p1", rdata[63:32], model_rd(r1));
        @(posedge clk);
        if (w && (wa != 5'd0)) arch[wa] = wd;
        #1;
    endtask

    task automatic sweep(input bit pulse, output int nd, output int nde);
        nd  = -1;
        nde = -1;
        for (int c = 1; c <= 40 && nd < 0; c++) begin
            raddr   = {5'($urandom), 5'($urandom)};
            e_raddr = raddr;
            if (pulse && c == 3) begin
                we    = 1'b1;
                waddr = 5'd5;
                wdata = 32'hDEADBEEF;
            end else begin
                we = 1'b0;
            end
            #2;
            if (!init_done) begin
                chk("init_rd_p0", rdata[31:0], 32'd0);
                chk("init_rd_p1", rdata[63:32], 32'd0);
            end
            if (!e_init_done) chk("init_rd_e", e_rdata[31:0], 32'd0);
            if (pulse && c == 3) chk("err_before_pulse", {31'd0, err}, 32'd0);
            @(posedge clk);
            #1;
            if (init_done && nd < 0) nd = c;
            if (e_init_done && nde < 0) nde = c;
        end
        we = 1'b0;
    endtask

    initial begin
        int nd, nde;
        logic [4:0] wa, r0, r1;

        tbl[0] = '{1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 32'd0, 32'd0};
        tbl[1] = '{1'b0, 5'd0, 32'd0, 5'd7, 5'd1, 32'h1234_5678, 32'd0};
        tbl[2] = '{1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678};
        tbl[3] = '{1'b1, 5'd3, 32'hA, 5'd3, 5'd3, 32'd0, 32'd0};
        tbl[4] = '{1'b1, 5'd3, 32'hB, 5'd3, 5'd3, 32'hA, 32'hA};
        tbl[5] = '{1'b1, 5'd4, 32'hC, 5'd3, 5'd4, 32'hB, 32'd0};
        tbl[6] = '{1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 32'hB, 32'hC};
        tbl[7] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'd0, 32'd0};
        tbl[8] = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 32'd0, 32'h1234_5678};
        tbl[9] = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd3, 32'd0, 32'hB};

        clear_model();
        rst_n = 1'b0;
        dummy = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = {5'd9, 5'd1};
        e_dummy = 1'b0; e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_raddr = '0;
        #12;
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd", rdata[31:0], 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep(1'b1, nd, nde);
        chk("init_len", nd, 31);
        chk("init_len_e", nde, 15);
        chk("err_sticky", {31'd0, err}, 32'd1);
        run_cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);

        for (int i = 0; i < 10; i++) begin
            we    = tbl[i].we;
            waddr = tbl[i].wa;
            wdata = tbl[i].wd;
            raddr = {tbl[i].r1, tbl[i].r0};
            #2;
            chk($sformatf("vec%0d_p0", i), rdata[31:0], tbl[i].e0);
            chk($sformatf("vec%0d_p1", i), rdata[63:32], tbl[i].e1);
            @(posedge clk);
            if (tbl[i].we && tbl[i].wa != 5'd0) arch[tbl[i].wa] = tbl[i].wd;
            #1;
        end

        for (int i = 0; i < 300; i++) begin
            wa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            r0 = ($urandom_range(0, 1) == 1) ? waddr : 5'($urandom);
            r1 = ($urandom_range(0, 2) == 0) ? r0 : 5'($urandom);
            dummy = 1'($urandom);
            run_cycle(1'($urandom), wa, $urandom, r0, r1);
        end
        chk("err_still_set", {31'd0, err}, 32'd1);
        we = 1'b0;
        dummy = 1'b0;

        e_we = 1'b1; e_waddr = 5'd0; e_wdata = 32'hFFFF_FFFF; e_dummy = 1'b1;
        @(posedge clk); #1;
        e_we = 1'b0;
        @(posedge clk); #1;
        e_raddr = '0; e_dummy = 1'b1;
        #2;
        chk("e_x0_dummy", e_rdata[31:0], 32'hFFFF_FFFF);
        chk("e_x0_dummy_p1", e_rdata[63:32], 32'hFFFF_FFFF);
        e_dummy = 1'b0;
        #2;
        chk("e_x0_nodummy", e_rdata[31:0], 32'd0);
        e_we = 1'b1; e_waddr = 5'h13; e_wdata = 32'h33; e_raddr = {5'h13, 5'h03};
        #1;
        chk("e_x3_same_cycle", e_rdata[31:0], 32'd0);
        @(posedge clk); #1;
        e_we = 1'b0;
        #2;
        chk("e_x3_fwd", e_rdata[31:0], 32'h33);
        chk("e_x13_alias_fwd", e_rdata[63:32], 32'h33);
        @(posedge clk); #1;
        e_raddr = {5'h04, 5'h03};
        #2;
        chk("e_x3_stored", e_rdata[31:0], 32'h33);
        chk("e_x4_untouched", e_rdata[63:32], 32'd0);
        e_we = 1'b1; e_waddr = 5'd0; e_wdata = 32'h1234; e_dummy = 1'b0;
        @(posedge clk); #1;
        e_we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e_dummy = 1'b1; e_raddr = '0;
        #2;
        chk("e_x0_nondummy_write_dropped", e_rdata[31:0], 32'hFFFF_FFFF);
        chk("e_err", {31'd0, e_err}, 32'd0);
        e_dummy = 1'b0;

        run_cycle(1'b1, 5'd9, 32'h55, 5'd9, 5'd10);
        run_cycle(1'b1, 5'd10, 32'h77, 5'd9, 5'd10);
        rst_n = 1'b0;
        we = 1'b0;
        clear_model();
        #1;
        chk("midrst_init_done", {31'd0, init_done}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep(1'b0, nd, nde);
        chk("reinit_len", nd, 31);
        chk("reinit_len_e", nde, 15);
        run_cycle(1'b0, 5'd0, 32'd0, 5'd9, 5'd10);
        e_raddr = {5'd0, 5'd3};
        #2;
        chk("e_x3_after_reset", e_rdata[31:0], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
